// File: rtl/iram_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: state encoding and data widths.
package iram_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int HALF_W  = 16;

    localparam logic [INSTR_W-1:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/iram_loader.sv
// Packs a halfword stream (high half first) into 32-bit words and writes them
// sequentially into the instruction RAM, holding the core off until done.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int                 ADDR_W   = 5,
    parameter logic [INSTR_W-1:0] END_WORD = END_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic [HALF_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                we,
    output logic [ADDR_W-1:0]   waddr,
    output logic [INSTR_W-1:0]  wdata,
    output logic [ADDR_W:0]     word_cnt,
    output logic                comp,
    output logic                full,
    output logic                core_hold
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_r;
    logic [HALF_W-1:0]   hi_r;
    logic [INSTR_W-1:0]  word_s;

    assign word_s = {hi_r, in_data};

    // Handshake ready and core hold-off decode straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b0;
        case (state_r)
            ST_LOAD_HI, ST_LOAD_LO: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
            end
            ST_WRITE: begin
                in_ready  = 1'b0;
                core_hold = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                core_hold = 1'b0;
            end
        endcase
    end

    // Loader FSM with packing register, write port and session counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            hi_r     <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            word_cnt <= '0;
            comp     <= 1'b0;
            full     <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (ld) begin
                        state_r  <= ST_LOAD_HI;
                        waddr    <= '0;
                        word_cnt <= '0;
                        comp     <= 1'b0;
                        full     <= 1'b0;
                    end
                end
                ST_LOAD_HI: begin
                    if (in_valid) begin
                        hi_r    <= in_data;
                        state_r <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    // The terminator is recognised on the whole word and never written.
                    if (in_valid) begin
                        if (word_s == END_WORD) begin
                            state_r <= ST_DONE;
                            comp    <= 1'b1;
                            full    <= 1'b0;
                        end else begin
                            wdata   <= word_s;
                            we      <= 1'b1;
                            state_r <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt + CNT_ONE;
                    // Last location: stop without wrapping so waddr still names the final word.
                    if (waddr == LAST_ADDR) begin
                        state_r <= ST_DONE;
                        comp    <= 1'b1;
                        full    <= 1'b1;
                    end else begin
                        waddr   <= waddr + ADDR_ONE;
                        state_r <= ST_LOAD_HI;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: directed and randomized sessions on a
// 32-deep and a 4-deep loader, checked against a stream-level reference model.
module tb_iram_loader;
    import iram_loader_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        ld;
    logic        iv;
    logic [15:0] idat;

    logic        ld_a, iv_a, rdy_a, we_a, comp_a, full_a, hold_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [5:0]  cnt_a;
    logic        ld_b, iv_b, rdy_b, we_b, comp_b, full_b, hold_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;

    assign ld_a = ld & ~sel;
    assign iv_a = iv & ~sel;
    assign ld_b = ld & sel;
    assign iv_b = iv & sel;

    iram_loader #(.ADDR_W(5)) dut_a (
        .clk(clk), .rst(rst), .ld(ld_a), .in_data(idat), .in_valid(iv_a),
        .in_ready(rdy_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .word_cnt(cnt_a), .comp(comp_a), .full(full_a), .core_hold(hold_a)
    );

    iram_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ld(ld_b), .in_data(idat), .in_valid(iv_b),
        .in_ready(rdy_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .word_cnt(cnt_b), .comp(comp_b), .full(full_b), .core_hold(hold_b)
    );

    logic        cur_rdy, cur_we, cur_comp, cur_full, cur_hold;
    logic [4:0]  cur_waddr;
    logic [31:0] cur_wdata;
    logic [5:0]  cur_cnt;

    assign cur_rdy   = sel ? rdy_b  : rdy_a;
    assign cur_we    = sel ? we_b   : we_a;
    assign cur_comp  = sel ? comp_b : comp_a;
    assign cur_full  = sel ? full_b : full_a;
    assign cur_hold  = sel ? hold_b : hold_a;
    assign cur_waddr = sel ? {3'b000, waddr_b} : waddr_a;
    assign cur_wdata = sel ? wdata_b : wdata_a;
    assign cur_cnt   = sel ? {3'b000, cnt_b} : cnt_a;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc     = 0;
    logic        xfer_now = 1'b0;
    int          got_addr[$];
    logic [31:0] got_data[$];

    logic [31:0] exp_w[$];
    bit          exp_comp;
    bit          exp_full;
    int          exp_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pair halfwords into words, stop at the terminator or when the RAM is full.
    function automatic void model(input logic [15:0] hw[$], input int depth);
        logic [31:0] word;
        exp_w.delete();
        exp_comp = 1'b0;
        exp_full = 1'b0;
        exp_acc  = 0;
        for (int i = 0; i + 1 < hw.size(); i += 2) begin
            word = {hw[i], hw[i+1]};
            exp_acc += 2;
            if (word == END_WORD_DEFAULT) begin
                exp_comp = 1'b1;
                break;
            end
            exp_w.push_back(word);
            if (exp_w.size() == depth) begin
                exp_comp = 1'b1;
                exp_full = 1'b1;
                break;
            end
        end
    endfunction

    function automatic logic pattern(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Write/handshake monitor on the selected loader, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (cur_we) begin
                got_addr.push_back(int'(cur_waddr));
                got_data.push_back(cur_wdata);
                check("in_ready_in_write", 64'(cur_rdy), 64'd0);
                check("we_after_lo_xfer", 64'(xfer_now), 64'd1);
            end
            xfer_now <= iv && cur_rdy;
            if (iv && cur_rdy) acc <= acc + 1;
        end
    end

    task automatic run_session(input logic [15:0] hw[$], input int mode, input bit poke, input int extra);
        int depth, idx, cyc, acc0, base;
        bit poked;
        depth = sel ? 4 : 32;
        model(hw, depth);
        ld = 1'b1; iv = 1'b0;
        step();
        ld = 1'b0;
        acc0 = acc;
        base = got_addr.size();
        check("start_comp", 64'(cur_comp), 64'd0);
        check("start_full", 64'(cur_full), 64'd0);
        check("start_word_cnt", 64'(cur_cnt), 64'd0);
        check("start_waddr", 64'(cur_waddr), 64'd0);
        check("start_core_hold", 64'(cur_hold), 64'd1);
        check("start_in_ready", 64'(cur_rdy), 64'd1);
        idx = 0; cyc = 0; poked = 1'b0;
        while (cur_comp !== 1'b1 && cyc < 400) begin
            if (poke && idx == 1 && !poked) begin
                ld = 1'b1; iv = 1'b0; poked = 1'b1;
            end else begin
                ld = 1'b0;
                iv = (idx < hw.size()) && pattern(mode, cyc);
                idat = (idx < hw.size()) ? hw[idx] : 16'h0000;
            end
            step();
            cyc++;
            if (xfer_now) idx++;
            if (cur_comp !== 1'b1) check("core_hold_active", 64'(cur_hold), 64'd1);
        end
        ld = 1'b0; iv = 1'b0;
        check("session_done_in_time", 64'(cyc < 400), 64'd1);
        check("done_comp", 64'(cur_comp), 64'(exp_comp));
        check("done_full", 64'(cur_full), 64'(exp_full));
        check("done_core_hold", 64'(cur_hold), 64'd0);
        check("done_in_ready", 64'(cur_rdy), 64'd0);
        check("done_word_cnt", 64'(cur_cnt), 64'(exp_w.size()));
        check("done_waddr", 64'(cur_waddr), exp_full ? 64'(depth - 1) : 64'(exp_w.size()));
        repeat (extra) begin
            iv = 1'b1; idat = 16'($urandom);
            step();
        end
        iv = 1'b0;
        check("done_comp_hold", 64'(cur_comp), 64'(exp_comp));
        check("halfwords_accepted", 64'(acc - acc0), 64'(exp_acc));
        check("write_count", 64'(got_addr.size() - base), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            if (base + i < got_addr.size()) begin
                check("write_addr", 64'(got_addr[base+i]), 64'(i));
                check("write_data", 64'(got_data[base+i]), 64'(exp_w[i]));
            end
        end
    endtask

    initial begin
        logic [15:0] q[$];
        sel = 1'b0; ld = 1'b0; iv = 1'b0; idat = 16'h0000; rst = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("rst_in_ready", 64'(cur_rdy), 64'd0);
            check("rst_we", 64'(cur_we), 64'd0);
            check("rst_comp", 64'(cur_comp), 64'd0);
            check("rst_full", 64'(cur_full), 64'd0);
            check("rst_core_hold", 64'(cur_hold), 64'd0);
            check("rst_waddr", 64'(cur_waddr), 64'd0);
            check("rst_wdata", 64'(cur_wdata), 64'd0);
            check("rst_word_cnt", 64'(cur_cnt), 64'd0);
        end
        sel = 1'b0;
        rst = 1'b1;
        step();

        // Data offered while idle must be ignored.
        begin
            int acc0;
            acc0 = acc;
            iv = 1'b1; idat = 16'h1234;
            step(); step();
            iv = 1'b0;
            check("idle_no_accept", 64'(acc - acc0), 64'd0);
            check("idle_in_ready", 64'(cur_rdy), 64'd0);
        end

        q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFFFF, 16'hFFFF};
        run_session(q, 0, 1'b0, 0);
        run_session(q, 1, 1'b0, 2);

        sel = 1'b1;
        q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606,
              16'h0707, 16'h0808, 16'h0909};
        run_session(q, 0, 1'b0, 4);

        sel = 1'b0;
        q = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'hFFFF};
        run_session(q, 0, 1'b1, 0);

        // Asynchronous reset landing in the middle of a write cycle.
        ld = 1'b1; step(); ld = 1'b0;
        iv = 1'b1; idat = 16'hCAFE; step();
        idat = 16'hBABE; step();
        iv = 1'b0;
        check("we_before_reset", 64'(cur_we), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_we", 64'(cur_we), 64'd0);
        check("arst_in_ready", 64'(cur_rdy), 64'd0);
        check("arst_comp", 64'(cur_comp), 64'd0);
        check("arst_full", 64'(cur_full), 64'd0);
        check("arst_core_hold", 64'(cur_hold), 64'd0);
        check("arst_waddr", 64'(cur_waddr), 64'd0);
        check("arst_wdata", 64'(cur_wdata), 64'd0);
        check("arst_word_cnt", 64'(cur_cnt), 64'd0);
        #3;
        rst = 1'b1;
        q = '{16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF};
        run_session(q, 0, 1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            int nw;
            logic [15:0] h;
            logic [15:0] l;
            sel = 1'(r % 2);
            nw = $urandom_range(0, 6);
            q.delete();
            repeat (nw) begin
                h = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                l = 16'($urandom);
                if ({h, l} == END_WORD_DEFAULT) l = 16'h0000;
                q.push_back(h);
                q.push_back(l);
            end
            q.push_back(16'hFFFF);
            q.push_back(16'hFFFF);
            run_session(q, 2, 1'b0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
